// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter: default sizes, ROM pin levels
// and a constant-evaluable ceil(log2) helper.
package rom_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ROM_DEPTH = 1024;
  localparam int DEF_NUM_DATA  = 1;
  localparam int DEF_BIT_WIDTH = 16;

  localparam logic ROM_ENABLE  = 1'b0;
  localparam logic ROM_DISABLE = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_arb_rsp_fifo.sv
// Two-entry {id,data} response buffer. When empty, a push is visible at the
// head in the same cycle so the ROM read data reaches the consumer directly.
module rom_arb_rsp_fifo #(
  parameter int ID_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ID_W-1:0]   push_id,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [ID_W-1:0]   head_id,
  output logic [DATA_W-1:0] head_data
);

  logic [ID_W-1:0]   id_q   [2];
  logic [ID_W-1:0]   id_d   [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              bypass;

  // Push+pop at count 0 writes a slot and advances both pointers: net empty.
  always_comb begin
    id_d     = id_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      id_d[wr_ptr_q]   = push_id;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '{default: '0};
      data_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      id_q     <= id_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bypass     = (count_q == 2'd0) && push;
  assign count      = count_q;
  assign head_valid = (count_q != 2'd0) || push;
  assign head_id    = bypass ? push_id   : id_q[rd_ptr_q];
  assign head_data  = bypass ? push_data : data_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM among NUM_REQ readers.
// Define ROM_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int  NUM_REQ   = DEF_NUM_REQ,
  parameter int  ROM_DEPTH = DEF_ROM_DEPTH,
  parameter int  NUM_DATA  = DEF_NUM_DATA,
  parameter int  BIT_WIDTH = DEF_BIT_WIDTH,
  localparam int ADDR_W    = clog2(ROM_DEPTH),
  localparam int DATA_W    = NUM_DATA * BIT_WIDTH,
  localparam int ID_W      = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready,
  output logic                      rom_cen,
  output logic [ADDR_W-1:0]         rom_A,
  input  logic [DATA_W-1:0]         rom_Q
);

  logic [ADDR_W-1:0] addr_slice [NUM_REQ];
  logic              any_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              pop, issue_ok, issue;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              inflight_q, inflight_d;
  logic [ID_W-1:0]   inflight_id_q, inflight_id_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
    assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign req_ready[gi]  = issue && (grant_idx == ID_W'(gi));
  end

`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'(k)]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] cand;

  // Scan clients starting at the pointer, wrapping; first requester wins.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  // The in-flight read already owns a buffer slot; a same-cycle pop frees one.
  assign pop       = rsp_valid & rsp_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok  = occupancy < 3'd2;
  assign issue     = rst_n & any_valid & issue_ok;
  assign rom_cen   = issue ? ROM_ENABLE : ROM_DISABLE;
  assign rom_A     = issue ? addr_slice[grant_idx] : rom_a_q;

  always_comb begin
    inflight_d    = issue;
    inflight_id_d = issue ? grant_idx : inflight_id_q;
    rom_a_d       = rom_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      rom_a_q       <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= '0;
`endif
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      rom_a_q       <= rom_a_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  rom_arb_rsp_fifo #(
    .ID_W   (ID_W),
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_id    (inflight_id_q),
    .push_data  (rom_Q),
    .pop        (pop),
    .count      (fifo_count),
    .head_valid (rsp_valid),
    .head_id    (rsp_id),
    .head_data  (rsp_data)
  );

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
Shares one synchronous ROM macro (active-low chip enable, registered Q, 1-cycle read latency) among NUM_REQ read clients, such as weight/bias fetch units.
- Arbitrates per-client valid/ready requests round-robin.
- Drives the ROM cen/A pins and captures Q one cycle later.
- Returns data tagged with the client ID through a 2-entry response buffer with valid/ready backpressure.

Parameters:
NUM_REQ, 4, number of requesting clients (>=2)
ROM_DEPTH, 1024, ROM words; ADDR_W = clog2(ROM_DEPTH)
NUM_DATA, 1, data items per ROM word
BIT_WIDTH, 16, bits per data item; DATA_W = NUM_DATA*BIT_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-client read request
req_addr  in  NUM_REQ*ADDR_W  per-client address; client i uses slice [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  per-client accept; one-hot or zero
rsp_valid  out  1  response buffer head valid
rsp_id  out  clog2(NUM_REQ)  client index of head response
rsp_data  out  DATA_W  head response data
rsp_ready  in  1  consumer accepts head
rom_cen  out  1  ROM chip enable, active-low
rom_A  out  ADDR_W  ROM address
rom_Q  in  DATA_W  ROM read data, valid the cycle after rom_cen=0

Behaviour:
- Reset (async, rst_n=0):
  - Clears the RR pointer, the in-flight flag, the in-flight ID, the FIFO count and the FIFO pointers.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rom_A register=0.
  - rom_cen=1 and req_ready=0 are forced combinationally while rst_n=0.
- pop = rsp_valid & rsp_ready.
- issue_ok = (fifo_count + inflight - pop) < 2. A pop in the same cycle frees a slot, so a continuously ready consumer sees 1 read per cycle.
- Arbitration:
  - Grant = first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only when issue_ok and rst_n=1. All other bits are 0.
- Issue cycle (a handshake occurs):
  - rom_cen=0 (combinational) and rom_A = req_addr slice g.
  - Registers set: inflight<=1, inflight_id<=g, rr_ptr<=(g+1) mod NUM_REQ.
- Non-issue cycle:
  - rom_cen=1.
  - rom_A holds its last issued value; a registered copy is kept to avoid address toggling.
  - rr_ptr is unchanged.
  - inflight<=0.
- Capture: on the cycle after an issue (inflight=1), {inflight_id, rom_Q} is written into the FIFO tail.
- FIFO:
  - 2 entries; head drives rsp_valid/rsp_id/rsp_data.
  - Simultaneous push and pop is legal at any count; count is unchanged.
  - Overflow is impossible by construction; this is an assertion target.
- Latency: request handshake at cycle T means rsp_valid at T+1 at the earliest (empty FIFO).
- Ordering: responses return in issue order.
- rsp_* is stable while rsp_valid & !rsp_ready.
- Mid-operation reset discards in-flight reads and buffered responses. A late rom_Q is ignored.
- Requesters must hold req_valid/req_addr until req_ready. The arbiter itself does not require this; it re-arbitrates every cycle.

Optional Feature:
ROM_ARB_FIXED_PRIO_EN
- Defined: grant = lowest-index asserted req_valid; rr_ptr is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package rom_arb_pkg holds:
  - clog2 function.
  - ROM_ENABLE=1'b0 and ROM_DISABLE=1'b1 constants.
  - Default parameter values.
- One natural sub-module, rom_arb_rsp_fifo: 2-entry {id,data} FIFO with push/pop/count.

Test Plan:
1. Single client 0 requests addr 0x005, rsp_ready=1 -> rom_cen=0 and rom_A=0x005 in cycle T; rsp_valid=1, rsp_id=0, rsp_data=model(0x005) in T+1.
2. All 4 clients hold req_valid with addresses 0x10..0x13, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches; no idle cycles.
3. rsp_ready=0 with continuous requests -> exactly 2 issues, then req_ready=0 and rom_cen=1. Raising rsp_ready resumes issuing in the same cycle.
4. Only clients 1 and 3 active, rr_ptr=2 -> grant 3 then 1; pointer wraps correctly.
5. Assert rst_n=0 one cycle after an issue with 1 buffered response -> rsp_valid=0 immediately; after release, no stale response and rom_cen=1 until a new request.
6. ROM_ARB_FIXED_PRIO_EN build, clients 0 and 2 both always valid -> client 0 granted every cycle; client 2 starved.
